// File: rtl/mlx_register_reader.sv
// rtl/mlx_register_reader.sv - MLX90640 burst register-read sequencer driving i2c_controller
//
// Ports:
//   clk, not_reset                 system clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake (ready only in IDLE)
//   req_register, req_count        first 16-bit register address, number of words
//   address, read_write,
//   transmit_data, enable_transfer command outputs to i2c_controller
//   idle, ack, nack, received_data status/data from i2c_controller (slower domain)
//   word_valid/data/index/last     one strobe per received big-endian word
//   busy, done, error              status; done/error are one-cycle pulses

`timescale 1ns/1ps

module mlx_register_reader #(
  parameter logic [6:0] DEVICE_ADDRESS = 7'h33,
  parameter int          COUNT_WIDTH    = 10,
  parameter int          TIMEOUT_CYCLES = 24000
) (
  input  logic                   clk,
  input  logic                   not_reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [15:0]            req_register,
  input  logic [COUNT_WIDTH-1:0] req_count,
  output logic [6:0]             address,
  output logic                   read_write,
  output logic [7:0]             transmit_data,
  output logic                   enable_transfer,
  input  logic                   idle,
  input  logic                   ack,
  input  logic                   nack,
  input  logic [7:0]             received_data,
  output logic                   word_valid,
  output logic [15:0]            word_data,
  output logic [COUNT_WIDTH-1:0] word_index,
  output logic                   word_last,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_HI,
    S_WR_LO,
    S_WR_STOP,
    S_RD,
    S_RD_STOP,
    S_ERR
  } state_t;

  state_t                 state_q, state_d;
  logic [15:0]            reg_q, reg_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] index_q, index_d;
  logic                   byte_odd_q, byte_odd_d;
  logic [7:0]             hi_byte_q, hi_byte_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [1:0]             ack_mon_q, ack_mon_d;
  logic [1:0]             nack_mon_q, nack_mon_d;
  logic                   enable_transfer_q, enable_transfer_d;
  logic                   read_write_q, read_write_d;
  logic [7:0]             transmit_data_q, transmit_data_d;
  logic                   word_valid_q, word_valid_d;
  logic [15:0]            word_data_q, word_data_d;
  logic [COUNT_WIDTH-1:0] word_index_q, word_index_d;
  logic                   word_last_q, word_last_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic success;
  logic failure;
  logic timed_state;
  logic timeout;

  // ack/nack are levels from a slower domain; a 0->1 step across the
  // two-stage monitor marks exactly one event cycle per controller byte.
  assign success     = (ack_mon_q == 2'b01);
  assign failure     = (nack_mon_q == 2'b01);
  assign timed_state = (state_q inside {S_WR_HI, S_WR_LO, S_WR_STOP, S_RD, S_RD_STOP});
  assign timeout     = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d         = state_q;
    reg_d           = reg_q;
    count_d         = count_q;
    index_d         = index_q;
    byte_odd_d      = byte_odd_q;
    hi_byte_d       = hi_byte_q;
    timer_d         = '0;
    ack_mon_d       = {ack_mon_q[0], ack};
    nack_mon_d      = {nack_mon_q[0], nack};
    read_write_d    = read_write_q;
    transmit_data_d = transmit_data_q;
    word_valid_d    = 1'b0;
    word_data_d     = word_data_q;
    word_index_d    = word_index_q;
    word_last_d     = word_last_q;
    done_d          = 1'b0;
    error_d         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          reg_d      = req_register;
          count_d    = req_count;
          index_d    = '0;
          byte_odd_d = 1'b0;
          if (req_count == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_WR_HI;
          end
        end
      end

      S_WR_HI: begin
        if (failure)      state_d = S_ERR;
        else if (success) state_d = S_WR_LO;
        else if (timeout) state_d = S_ERR;
      end

      S_WR_LO: begin
        if (failure)      state_d = S_ERR;
        else if (success) state_d = S_WR_STOP;
        else if (timeout) state_d = S_ERR;
      end

      S_WR_STOP: begin
        if (idle)         state_d = S_RD;
        else if (timeout) state_d = S_ERR;
      end

      S_RD: begin
        if (failure) begin
          state_d = S_ERR;
        end else if (success) begin
          if (!byte_odd_q) begin
            hi_byte_d  = received_data;
            byte_odd_d = 1'b1;
          end else begin
            byte_odd_d   = 1'b0;
            word_valid_d = 1'b1;
            word_data_d  = {hi_byte_q, received_data};
            word_index_d = index_q;
            word_last_d  = (index_q == count_q - COUNT_WIDTH'(1));
            index_d      = index_q + COUNT_WIDTH'(1);
            if (index_q == count_q - COUNT_WIDTH'(1)) begin
              state_d = S_RD_STOP;
            end
          end
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_RD_STOP: begin
        if (idle) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (timeout) begin
          state_d = S_ERR;
        end
      end

      S_ERR: begin
        if (idle) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Timer restarts on every state change and every acknowledged byte.
    if (timed_state && (state_d == state_q) && !success) begin
      timer_d = timer_q + TW'(1);
    end

    // Controller commands follow the next state so they change on the
    // same edge as the transition (enable drops as the last byte lands).
    enable_transfer_d = (state_d inside {S_WR_HI, S_WR_LO, S_RD});
    case (state_d)
      S_WR_HI: begin
        read_write_d    = 1'b0;
        transmit_data_d = reg_d[15:8];
      end
      S_WR_LO: transmit_data_d = reg_d[7:0];
      S_RD:    read_write_d    = 1'b1;
      default: ;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge not_reset) begin
    if (!not_reset) begin
      state_q           <= S_IDLE;
      reg_q             <= '0;
      count_q           <= '0;
      index_q           <= '0;
      byte_odd_q        <= 1'b0;
      hi_byte_q         <= '0;
      timer_q           <= '0;
      ack_mon_q         <= '0;
      nack_mon_q        <= '0;
      enable_transfer_q <= 1'b0;
      read_write_q      <= 1'b0;
      transmit_data_q   <= '0;
      word_valid_q      <= 1'b0;
      word_data_q       <= '0;
      word_index_q      <= '0;
      word_last_q       <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      error_q           <= 1'b0;
    end else begin
      state_q           <= state_d;
      reg_q             <= reg_d;
      count_q           <= count_d;
      index_q           <= index_d;
      byte_odd_q        <= byte_odd_d;
      hi_byte_q         <= hi_byte_d;
      timer_q           <= timer_d;
      ack_mon_q         <= ack_mon_d;
      nack_mon_q        <= nack_mon_d;
      enable_transfer_q <= enable_transfer_d;
      read_write_q      <= read_write_d;
      transmit_data_q   <= transmit_data_d;
      word_valid_q      <= word_valid_d;
      word_data_q       <= word_data_d;
      word_index_q      <= word_index_d;
      word_last_q       <= word_last_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      error_q           <= error_d;
    end
  end

  assign req_ready       = (state_q == S_IDLE);
  assign address         = DEVICE_ADDRESS;
  assign read_write      = read_write_q;
  assign transmit_data   = transmit_data_q;
  assign enable_transfer = enable_transfer_q;
  assign word_valid      = word_valid_q;
  assign word_data       = word_data_q;
  assign word_index      = word_index_q;
  assign word_last       = word_last_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign error           = error_q;

endmodule
